mem_access_ctrl: RTL
====================

Name: mem_access_ctrl

Overview:
- Sequences data-memory accesses in the MEM stage against a variable-latency memory with a req/ack handshake.
- Stalls the front pipeline (PC, IF/ID, ID/EX, EX/MEM) while an access is outstanding.
- Forces a bubble into the MEM/WB register while stalled.
- Supplies the read data that MEM/WB captures as MemRes.

Parameters:
- TIMEOUT, 255: maximum WAIT cycles before the access is abandoned.
- CNT_W, 8: width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- mem_read  input  1  MEM-stage instruction is a load (from EX/MEM).
- mem_write  input  1  MEM-stage instruction is a store (from EX/MEM).
- addr_in  input  32  MEM-stage address (EX/MEM ALURes).
- wdata_in  input  32  MEM-stage store data.
- dmem_ack  input  1  memory completion strobe, 1 cycle.
- dmem_rdata  input  32  memory read data; valid only while dmem_ack=1.
- dmem_req  output  1  access request to memory.
- dmem_we  output  1  write enable; 1=store.
- dmem_addr  output  32  memory address.
- dmem_wdata  output  32  memory write data.
- stall  output  1  freezes PC, IF/ID, ID/EX, EX/MEM.
- wb_bubble  output  1  MEM/WB must load wb_RegWrite=0 and wb_MemToReg=0 on this edge.
- mem_res  output  32  read data toward MEM/WB MemRes_in.
- busy  output  1  state != IDLE.
- err  output  1  sticky timeout flag.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; cnt=0; err=0.
  - Latched addr/wdata/we/rdata registers = 0.
  - All outputs 0: dmem_req, stall, wb_bubble, busy, mem_res.
- Access condition: acc = mem_read | mem_write. mem_read and mem_write both high is treated as a store.
- States: IDLE, WAIT, RESP.
- IDLE:
  - dmem_req=acc.
  - dmem_addr/dmem_wdata/dmem_we driven combinationally from addr_in/wdata_in/mem_write.
  - acc=1 and dmem_ack=1 (zero-wait):
    - stall=0, wb_bubble=0, mem_res=dmem_rdata (bypass).
    - Stay in IDLE.
  - acc=1 and dmem_ack=0:
    - stall=1, wb_bubble=1.
    - Latch addr_in, wdata_in, mem_write; cnt<=0; go to WAIT.
  - acc=0:
    - stall=0, wb_bubble=0, mem_res=0.
    - dmem_ack ignored.
- WAIT:
  - dmem_req=1; addr/wdata/we driven from the latched registers.
  - stall=1, wb_bubble=1.
  - dmem_ack=1: rdata_q<=dmem_rdata (0 for a store); go to RESP.
  - Else if cnt==TIMEOUT-1: err<=1; rdata_q<=0; go to RESP with the timeout mark set.
  - Else cnt<=cnt+1.
  - ack and timeout in the same cycle: ack wins; err is not set.
- RESP (exactly 1 cycle):
  - dmem_req=0, stall=0, mem_res=rdata_q.
  - wb_bubble=0 after a normal completion; wb_bubble=1 after a timeout (squashes the register write).
  - dmem_ack ignored. Next state IDLE.
  - The following instruction enters MEM on this edge and is evaluated in IDLE next cycle.
- Latency:
  - Access acked N>=1 cycles after the request: stall high for N+1 cycles.
  - MEM/WB captures the valid load on the RESP edge.
  - Zero-wait access: no stall.
- dmem_addr/dmem_we/dmem_wdata hold stable from the first request cycle until the ack; the latched copies guarantee this even if EX/MEM glitches.
- err:
  - Sticky; cleared only by reset.
  - Does not block further accesses.
- Reset mid-WAIT:
  - Immediate IDLE; dmem_req drops asynchronously.
  - A late ack after reset is ignored unless a new acc is present.
- busy = (state != IDLE).

Test Plan:
- Zero-wait load:
  - Stimulus: mem_read=1, addr_in=0x10, dmem_ack=1, dmem_rdata=0xCAFEBABE in the same cycle.
  - Required: stall=0, wb_bubble=0, mem_res=0xCAFEBABE, dmem_req=1, state stays IDLE.
- 3-cycle load:
  - Stimulus: mem_read=1, addr_in=0x40; ack 3 cycles after the request with rdata=0x12345678.
  - Required: stall=1 and wb_bubble=1 for 4 cycles; dmem_addr=0x40 throughout; the RESP cycle shows stall=0, mem_res=0x12345678.
- Store, 2-cycle wait:
  - Stimulus: mem_write=1, addr_in=0x80, wdata_in=0xDEADBEEF; change addr_in to 0x0 during WAIT.
  - Required: dmem_we=1, dmem_addr=0x80, dmem_wdata=0xDEADBEEF held until ack; RESP shows mem_res=0.
- Timeout (TIMEOUT=4):
  - Stimulus: mem_read=1, ack never arrives.
  - Required: 4 WAIT cycles, then RESP with wb_bubble=1, mem_res=0, err=1 staying high.
  - A following zero-wait load completes normally with err still 1.
- Ack coincident with the last timeout cycle:
  - Required: err=0, mem_res=ack data, RESP wb_bubble=0.
- Reset in WAIT:
  - Stimulus: rst=0 for 1 cycle mid-wait.
  - Required: dmem_req, stall, busy drop immediately; err=0; a subsequent stray ack with acc=0 leaves state IDLE, mem_res=0.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage data-memory sequencer for a variable-latency
// memory with a req/ack handshake. It stalls the front pipeline while an
// access is outstanding, forces a bubble into MEM/WB while stalled, and
// supplies the read data captured by MEM/WB.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   mem_read/write    MEM-stage load/store (both high = store)
//   addr_in/wdata_in  MEM-stage address / store data
//   dmem_ack/rdata    memory completion strobe and read data
//   dmem_req/we/addr/wdata  memory request bus
//   stall             freezes PC, IF/ID, ID/EX, EX/MEM
//   wb_bubble         MEM/WB loads RegWrite=0, MemToReg=0
//   mem_res           read data toward MEM/WB
//   busy              state != IDLE
//   err               sticky timeout flag
module mem_access_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic        stall,
  output logic        wb_bubble,
  output logic [31:0] mem_res,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      addr_q, wdata_q, rdata_q;
  logic             we_q, to_q, err_q;
  logic             acc, last;

  assign acc  = mem_read | mem_write;
  assign last = (cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      to_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (acc && !dmem_ack) begin
          // Latch the request so the memory bus holds still even if
          // EX/MEM changes underneath us.
          addr_q  <= addr_in;
          wdata_q <= wdata_in;
          we_q    <= mem_write;
          cnt     <= '0;
          to_q    <= 1'b0;
        end
        WAIT: if (dmem_ack) begin
          // Ack beats a coincident timeout.
          rdata_q <= we_q ? 32'h0 : dmem_rdata;
          to_q    <= 1'b0;
        end else if (last) begin
          err_q   <= 1'b1;
          rdata_q <= '0;
          to_q    <= 1'b1;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt  = state;
    dmem_req   = 1'b0;
    dmem_we    = we_q;
    dmem_addr  = addr_q;
    dmem_wdata = wdata_q;
    stall      = 1'b0;
    wb_bubble  = 1'b0;
    mem_res    = '0;
    case (state)
      IDLE: begin
        dmem_req   = acc;
        dmem_we    = mem_write;
        dmem_addr  = addr_in;
        dmem_wdata = wdata_in;
        if (acc) begin
          if (dmem_ack) begin
            mem_res = dmem_rdata;   // zero-wait bypass, no stall
          end else begin
            stall     = 1'b1;
            wb_bubble = 1'b1;
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        dmem_req  = 1'b1;
        stall     = 1'b1;
        wb_bubble = 1'b1;
        if (dmem_ack || last) state_nxt = RESP;
      end
      RESP: begin
        mem_res   = rdata_q;
        wb_bubble = to_q;           // squash the write-back of a timed-out access
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Reset drops the request and pipeline controls without waiting for a clock.
    if (!rst) begin
      dmem_req  = 1'b0;
      dmem_we   = 1'b0;
      stall     = 1'b0;
      wb_bubble = 1'b0;
      mem_res   = '0;
    end
  end

  assign busy = (state != IDLE);
  assign err  = err_q;

endmodule
